// File: rtl/stage_sequencer.sv
// Loads a program over valid/ready, then cycles FETCH/DECODE/EXECUTE with halt/reload; one stage per cycle.
// Load beats are written to pmem combinationally in the accepting cycle; ready is high for every LOAD cycle and low otherwise.
module stage_sequencer #(
    parameter int PMEM_DEPTH = 256,
    parameter int ADDR_W     = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load_valid,
    input  logic [11:0]       i_load_data,
    input  logic              i_load_last,
    output logic              o_load_ready,
    output logic              o_pmem_we,
    output logic [ADDR_W-1:0] o_pmem_addr,
    output logic [11:0]       o_pmem_data,
    input  logic              i_halt,
    input  logic              i_reload,
    output logic [1:0]        o_Stage,
    output logic              o_halted,
    output logic [ADDR_W:0]   o_load_count,
    output logic              o_trunc,
    output logic [15:0]       o_instr_count
);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'b00,
        ST_FETCH   = 2'b01,
        ST_DECODE  = 2'b10,
        ST_EXECUTE = 2'b11
    } stage_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PMEM_DEPTH - 1);

    stage_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic              load_beat;

    assign load_beat    = (state == ST_LOAD) && i_load_valid;
    assign o_load_ready = (state == ST_LOAD);
    assign o_pmem_we    = load_beat;
    assign o_pmem_addr  = wr_ptr;
    assign o_pmem_data  = i_load_data;
    assign o_halted     = (state == ST_FETCH) && i_halt;
    assign o_Stage      = state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= ST_LOAD;
            wr_ptr        <= '0;
            o_load_count  <= '0;
            o_trunc       <= 1'b0;
            o_instr_count <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (load_beat) begin
                        wr_ptr       <= wr_ptr + 1'b1;
                        o_load_count <= o_load_count + 1'b1;
                        if (i_load_last) begin
                            state <= ST_FETCH;
                        end else if (wr_ptr == LAST_ADDR) begin
                            // Memory full with no end marker: run what we have and flag it.
                            state   <= ST_FETCH;
                            o_trunc <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    if (i_halt && i_reload) begin
                        state         <= ST_LOAD;
                        wr_ptr        <= '0;
                        o_load_count  <= '0;
                        o_trunc       <= 1'b0;
                        o_instr_count <= '0;
                    end else if (!i_halt) begin
                        state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    state         <= ST_FETCH;
                    o_instr_count <= o_instr_count + 16'd1;
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed + randomized bench for stage_sequencer; expected stages/counts derived arithmetically from elapsed run cycles.
module tb_stage_sequencer;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          i_rst, i_load_valid, i_load_last, i_halt, i_reload;
    logic [11:0]   i_load_data;
    logic          o_load_ready, o_pmem_we, o_halted, o_trunc;
    logic [AW-1:0] o_pmem_addr;
    logic [11:0]   o_pmem_data;
    logic [1:0]    o_Stage;
    logic [AW:0]   o_load_count;
    logic [15:0]   o_instr_count;

    int tests = 0;
    int fails = 0;
    int run_t = 0;  // cycles since entering FETCH after the last load (halted cycles excluded)
    logic [11:0] fixed_words [3];

    always #5 clk = ~clk;

    stage_sequencer #(.PMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_load_valid(i_load_valid), .i_load_data(i_load_data), .i_load_last(i_load_last),
        .o_load_ready(o_load_ready), .o_pmem_we(o_pmem_we), .o_pmem_addr(o_pmem_addr),
        .o_pmem_data(o_pmem_data), .i_halt(i_halt), .i_reload(i_reload),
        .o_Stage(o_Stage), .o_halted(o_halted), .o_load_count(o_load_count),
        .o_trunc(o_trunc), .o_instr_count(o_instr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Post-reset / post-reload idle LOAD state with no beat offered.
    task automatic check_cleared(input string tag);
        chk({tag, "_stage"}, o_Stage, 0);
        chk({tag, "_ready"}, o_load_ready, 1);
        chk({tag, "_we"}, o_pmem_we, 0);
        chk({tag, "_ptr"}, o_pmem_addr, 0);
        chk({tag, "_lcnt"}, o_load_count, 0);
        chk({tag, "_trunc"}, o_trunc, 0);
        chk({tag, "_icnt"}, o_instr_count, 0);
        chk({tag, "_halted"}, o_halted, 0);
    endtask

    // mode: 0 valid held, 1 toggling 1,0,1,0..., 2 random
    task automatic do_load(input int n, input bit use_last, input int mode, input bit fixed);
        int acc = 0;
        int exp_len = use_last ? n : DEPTH;
        bit v;
        for (int cyc = 0; cyc < 200 && acc < exp_len; cyc++) begin
            @(negedge clk);
            i_halt = 0; i_reload = 0;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            i_load_valid = v;
            i_load_data  = fixed ? fixed_words[acc] : 12'($urandom);
            i_load_last  = use_last && (acc == n - 1);
            #1;
            chk("load_ready", o_load_ready, 1);
            chk("load_stage", o_Stage, 0);
            chk("load_we", o_pmem_we, v);
            if (v) begin
                chk("load_addr", o_pmem_addr, acc);
                chk("load_data", o_pmem_data, i_load_data);
                acc++;
            end
        end
        if (acc < exp_len) chk("load_timeout", acc, exp_len);
        // First FETCH cycle: an extra beat on offer must be refused.
        @(negedge clk);
        i_load_valid = 1; i_load_last = 0; i_load_data = 12'($urandom);
        #1;
        chk("post_stage", o_Stage, 1);
        chk("post_ready", o_load_ready, 0);
        chk("post_we", o_pmem_we, 0);
        chk("post_lcnt", o_load_count, exp_len);
        chk("post_trunc", o_trunc, !use_last);
        chk("post_icnt", o_instr_count, 0);
        i_load_valid = 0;
        run_t = 1;
    endtask

    // Free-running cycles; reload and load beats are noise that must be ignored.
    task automatic run(input int k);
        for (int i = 0; i < k; i++) begin
            @(negedge clk);
            i_halt = 0;
            i_reload = 1'($urandom_range(0, 1));
            i_load_valid = 1'($urandom_range(0, 1));
            #1;
            chk("run_stage", o_Stage, 1 + run_t % 3);
            chk("run_icnt", o_instr_count, (run_t / 3) & 16'hFFFF);
            chk("run_halted", o_halted, 0);
            chk("run_ready", o_load_ready, 0);
            chk("run_we", o_pmem_we, 0);
            run_t++;
        end
        i_reload = 0; i_load_valid = 0;
    endtask

    task automatic go_reload();
        while (run_t % 3 != 0) run(1);
        @(negedge clk);
        i_halt = 1; i_reload = 1;
        #1;
        chk("rl_stage", o_Stage, 1);
        chk("rl_halted", o_halted, 1);
        chk("rl_icnt", o_instr_count, run_t / 3);
        @(negedge clk);
        i_halt = 0; i_reload = 0;
        #1;
        check_cleared("reload");
    endtask

    task automatic reset_after();
        @(negedge clk);
        i_rst = 0; i_load_valid = 0; i_halt = 0; i_reload = 0;
        #1;
        check_cleared("rst");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        fixed_words[0] = 12'h100;
        fixed_words[1] = 12'h2A5;
        fixed_words[2] = 12'h801;
        i_rst = 1; i_load_valid = 0; i_load_data = '0; i_load_last = 0;
        i_halt = 0; i_reload = 0;
        repeat (2) @(negedge clk);
        #1;
        check_cleared("init");
        reset_after();

        // Three-word program with valid held, then 10 instructions and a halt raised in DECODE.
        do_load(3, 1, 0, 1);
        run(30);
        @(negedge clk); i_halt = 1; #1;
        chk("halt_decode", o_Stage, 2);
        @(negedge clk); #1;
        chk("halt_exec", o_Stage, 3);
        chk("halt_exec_halted", o_halted, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("parked_stage", o_Stage, 1);
            chk("parked_halted", o_halted, 1);
            chk("parked_icnt", o_instr_count, 11);
        end
        @(negedge clk); i_halt = 0; #1;
        chk("release_stage", o_Stage, 1);
        chk("release_halted", o_halted, 0);
        @(negedge clk); #1;
        chk("release_decode", o_Stage, 2);
        run_t = 35;
        run(4);
        go_reload();

        // Toggling valid, then reset during EXECUTE.
        do_load(2, 1, 1, 0);
        run(10);
        @(negedge clk); i_rst = 1; #1;
        chk("rst_exec_stage", o_Stage, 3);
        reset_after();

        // Overflow without last marker.
        do_load(DEPTH + 1, 0, 0, 0);
        run(4);
        go_reload();

        // Random program lengths and valid patterns.
        for (int k = 0; k < 4; k++) begin
            do_load($urandom_range(1, DEPTH), 1, 2, 0);
            run($urandom_range(3, 12));
            go_reload();
        end

        // Reset mid-load with pointer at 5.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            i_load_valid = 1; i_load_last = 0; i_load_data = 12'($urandom);
        end
        @(negedge clk);
        i_load_valid = 1; i_rst = 1;
        #1;
        chk("rst_load_addr", o_pmem_addr, 5);
        chk("rst_load_lcnt", o_load_count, 5);
        reset_after();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
